// File: rtl/branch_compare_unit_pkg.sv
// Shared constants for the branch compare unit.
// Holds the condition-code encodings seen on in_ctrl and the FSM state encodings.
package branch_compare_unit_pkg;

  localparam int unsigned CtrlW = 4;

  // Codes 10-15 are unassigned and resolve as illegal.
  typedef enum logic [CtrlW-1:0] {
    CmpNever            = 4'd0,
    CmpEqual            = 4'd1,
    CmpNotEqual         = 4'd2,
    CmpLessEqualZero    = 4'd3,
    CmpLessThanZero     = 4'd4,
    CmpGreaterEqualZero = 4'd5,
    CmpGreaterThanZero  = 4'd6,
    CmpLessThan         = 4'd7,
    CmpLessThanUnsigned = 4'd8,
    CmpAlways           = 4'd9
  } cmp_ctrl_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/branch_compare_unit_cmp_eval.sv
// Combinational branch-condition evaluator.
// Ports:
//   a, b    : operands, two's complement
//   ctrl    : condition code
//   taken   : condition holds (always 0 for illegal codes)
//   illegal : ctrl is not one of the defined codes
module branch_compare_unit_cmp_eval
  import branch_compare_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CtrlW-1:0] ctrl,
  output logic             taken,
  output logic             illegal
);

  logic a_neg;
  logic a_zero;

  // Zero compares look only at the full-width sign bit and an all-zero test.
  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (ctrl)
      CmpNever:            taken = 1'b0;
      CmpEqual:            taken = (a == b);
      CmpNotEqual:         taken = (a != b);
      CmpLessEqualZero:    taken = a_neg | a_zero;
      CmpLessThanZero:     taken = a_neg;
      CmpGreaterEqualZero: taken = ~a_neg;
      CmpGreaterThanZero:  taken = ~a_neg & ~a_zero;
      CmpLessThan:         taken = ($signed(a) < $signed(b));
      CmpLessThanUnsigned: taken = (a < b);
      CmpAlways:           taken = 1'b1;
      default:             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_compare_unit.sv
// Registered branch-condition resolver.
// Accepts one branch per in_valid/in_ready handshake, holds it while an operand is still
// being forwarded, then presents a registered taken/target result on out_valid/out_ready.
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   in_valid/in_ready            : request handshake
//   in_ctrl, in_a, in_b          : condition code and operands
//   in_a_pending, in_b_pending   : operand not yet forwarded
//   in_target                    : branch target, passed through
//   flush                        : kills held or arriving branch
//   out_valid/out_ready          : result handshake
//   out_taken, out_target        : registered result
//   illegal_seen                 : sticky, an illegal code was delivered
//   resolved_count, taken_count  : saturating delivery statistics
module branch_compare_unit
  import branch_compare_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CtrlW-1:0] in_ctrl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_a_pending,
  input  logic             in_b_pending,
  input  logic [WIDTH-1:0] in_target,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [WIDTH-1:0] out_target,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] resolved_count,
  output logic [CNT_W-1:0] taken_count
);

  state_e           state_q, state_d;
  logic [CtrlW-1:0] ctrl_q;
  logic [WIDTH-1:0] target_q;
  logic             taken_q;
  logic             illegal_q;
  logic             illegal_seen_q;
  logic [CNT_W-1:0] resolved_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic             operands_ready;
  logic             accept;
  logic             eval_en;
  logic             deliver;
  logic [CtrlW-1:0] eval_ctrl;
  logic             eval_taken;
  logic             eval_illegal;

  assign operands_ready = ~in_a_pending & ~in_b_pending;
  assign in_ready       = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign out_valid      = (state_q == StDone);
  assign accept         = in_valid & in_ready;
  // While waiting the code comes from the held copy; otherwise straight from the request.
  assign eval_ctrl      = (state_q == StWait) ? ctrl_q : in_ctrl;
  assign eval_en        = operands_ready & (accept | (state_q == StWait));
  assign deliver        = out_valid & out_ready & ~flush;

  branch_compare_unit_cmp_eval #(
    .WIDTH (WIDTH)
  ) u_cmp_eval (
    .a       (in_a),
    .b       (in_b),
    .ctrl    (eval_ctrl),
    .taken   (eval_taken),
    .illegal (eval_illegal)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = operands_ready ? StDone : StWait;
      StWait: if (operands_ready) state_d = StDone;
      StDone: begin
        if (out_ready) begin
          if (in_valid) state_d = operands_ready ? StDone : StWait;
          else          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      ctrl_q         <= '0;
      target_q       <= '0;
      taken_q        <= 1'b0;
      illegal_q      <= 1'b0;
      illegal_seen_q <= 1'b0;
      resolved_q     <= '0;
      taken_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctrl_q   <= in_ctrl;
        target_q <= in_target;
      end
      if (eval_en) begin
        taken_q   <= eval_taken;
        illegal_q <= eval_illegal;
      end
      if (deliver) begin
        illegal_seen_q <= illegal_seen_q | illegal_q;
        if (resolved_q != {CNT_W{1'b1}}) resolved_q <= resolved_q + CNT_W'(1);
        if (taken_q && (taken_cnt_q != {CNT_W{1'b1}})) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_taken      = taken_q;
  assign out_target     = target_q;
  assign illegal_seen   = illegal_seen_q;
  assign resolved_count = resolved_q;
  assign taken_count    = taken_cnt_q;

endmodule

// File: tb/tb_branch_compare_unit.sv
// Self-checking bench for branch_compare_unit: directed scenarios plus randomized
// transactions checked against a behavioural condition model and delivery counts.
module tb_branch_compare_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [3:0]  in_ctrl;
  logic [31:0] in_a, in_b, in_target;
  logic        in_a_pending, in_b_pending;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, out_taken, illegal_seen;
  logic [31:0] out_target;
  logic [15:0] resolved_count, taken_count;

  logic        in_ready2, out_valid2, out_taken2, illegal_seen2;
  logic [31:0] out_target2;
  logic [1:0]  resolved_count2, taken_count2;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_res = 0;
  int exp_tkn = 0;
  bit exp_ill = 1'b0;

  always #5 clk = ~clk;

  branch_compare_unit #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .in_a_pending(in_a_pending),
    .in_b_pending(in_b_pending), .in_target(in_target), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .illegal_seen(illegal_seen),
    .resolved_count(resolved_count), .taken_count(taken_count)
  );

  branch_compare_unit #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .in_a_pending(in_a_pending),
    .in_b_pending(in_b_pending), .in_target(in_target), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .out_taken(out_taken2),
    .out_target(out_target2), .illegal_seen(illegal_seen2),
    .resolved_count(resolved_count2), .taken_count(taken_count2)
  );

  // Condition model: operands lifted to 64-bit signed/unsigned integers.
  function automatic bit ref_taken(input int c, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    case (c)
      1:       return sa == sb;
      2:       return sa != sb;
      3:       return sa <= 0;
      4:       return sa < 0;
      5:       return sa >= 0;
      6:       return sa > 0;
      7:       return sa < sb;
      8:       return ua < ub;
      9:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat16(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  function automatic int sat2(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 3));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] t, input logic pa, input logic pb);
    in_valid     = 1'b1;
    in_ctrl      = 4'(c);
    in_a         = a;
    in_b         = b;
    in_target    = t;
    in_a_pending = pa;
    in_b_pending = pb;
  endtask

  // Record one delivered result in the model.
  task automatic note_delivery(input int c, input bit tk);
    exp_res++;
    if (tk) exp_tkn++;
    if (c >= 10) exp_ill = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 0; in_ctrl = 0; in_a = 0; in_b = 0; in_target = 0;
    in_a_pending = 0; in_b_pending = 0; flush = 0; out_ready = 0;
    step(); step();
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b out_taken=%b required 1 0 0",
               in_ready, out_valid, out_taken);
    end
    n_cmp++;
    if (out_target !== 32'h0 || illegal_seen !== 1'b0 || resolved_count !== 16'h0 ||
        taken_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_regs: target=%h ill=%b res=%0d tkn=%0d required 0 0 0 0",
               out_target, illegal_seen, resolved_count, taken_count);
    end
  endtask

  task automatic test_eq();
    out_ready = 1'b1;
    drive_req(1, 32'h5, 32'h5, 32'h100, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_target !== 32'h100) begin
      n_fail++;
      $display("FAIL eq_result: valid=%b taken=%b target=%h required 1 1 100",
               out_valid, out_taken, out_target);
    end
    step();
    note_delivery(1, 1'b1);
    n_cmp++;
    if (resolved_count !== 16'd1 || taken_count !== 16'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL eq_counters: res=%0d tkn=%0d valid=%b required 1 1 0",
               resolved_count, taken_count, out_valid);
    end
  endtask

  task automatic test_compares();
    int          cs[13] = '{7, 8, 6, 3, 4, 5, 6, 2, 0, 9, 1, 3, 5};
    logic [31:0] as[13] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h8000_0000,
                            32'h0, 32'h1, 32'h3, 32'h0, 32'h0, 32'h1, 32'h7FFF_FFFF,
                            32'h8000_0000};
    logic [31:0] bs[13] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0,
                            32'h0, 32'h2, 32'h0, 32'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bit          tk = ref_taken(cs[i], as[i], bs[i]);
      logic [31:0] t  = 32'h1000 + 32'(i * 4);
      drive_req(cs[i], as[i], bs[i], t, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_taken !== tk || out_target !== t) begin
        n_fail++;
        $display("FAIL cmp_code%0d: valid=%b taken=%b target=%h required 1 %b %h",
                 cs[i], out_valid, out_taken, out_target, tk, t);
      end
      step();
      note_delivery(cs[i], tk);
    end
    n_cmp++;
    if (resolved_count !== 16'(sat16(exp_res)) || taken_count !== 16'(sat16(exp_tkn))) begin
      n_fail++;
      $display("FAIL cmp_counters: res=%0d tkn=%0d required %0d %0d",
               resolved_count, taken_count, exp_res, exp_tkn);
    end
  endtask

  task automatic test_pending();
    out_ready = 1'b0;
    drive_req(2, 32'd9, 32'd7, 32'h200, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_b = 32'd7 + 32'(k);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL pend_wait%0d: valid=%b in_ready=%b required 0 0", k, out_valid, in_ready);
      end
      step();
    end
    in_b = 32'd9;
    in_b_pending = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_taken !== 1'b0 || out_target !== 32'h200) begin
      n_fail++;
      $display("FAIL pend_result: valid=%b taken=%b target=%h required 1 0 200",
               out_valid, out_taken, out_target);
    end
    out_ready = 1'b1;
    step();
    note_delivery(2, 1'b0);
    n_cmp++;
    if (resolved_count !== 16'(sat16(exp_res)) || taken_count !== 16'(sat16(exp_tkn))) begin
      n_fail++;
      $display("FAIL pend_counters: res=%0d tkn=%0d required %0d %0d",
               resolved_count, taken_count, exp_res, exp_tkn);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive_req(7, 32'hFFFF_FFFB, 32'd3, 32'h300, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_a = 32'($urandom());
      n_cmp++;
      if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_target !== 32'h300 ||
          in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b taken=%b target=%h in_ready=%b required 1 1 300 0",
                 k, out_valid, out_taken, out_target, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    drive_req(8, 32'd1, 32'd2, 32'h304, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: in_ready=%b required 1", in_ready);
    end
    step();
    note_delivery(7, 1'b1);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_taken !== ref_taken(8, 32'd1, 32'd2) ||
        out_target !== 32'h304) begin
      n_fail++;
      $display("FAIL stall_b2b: valid=%b taken=%b target=%h required 1 1 304",
               out_valid, out_taken, out_target);
    end
    step();
    note_delivery(8, 1'b1);
    n_cmp++;
    if (resolved_count !== 16'(sat16(exp_res)) || taken_count !== 16'(sat16(exp_tkn)) ||
        out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_counters: res=%0d tkn=%0d valid=%b required %0d %0d 0",
               resolved_count, taken_count, out_valid, exp_res, exp_tkn);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive_req(1, 32'd4, 32'd4, 32'h400, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_wait: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    in_a_pending = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_wait_late: valid=%b required 0", out_valid);
    end
    out_ready = 1'b0;
    drive_req(9, 32'd0, 32'd0, 32'h410, 1'b0, 1'b0);
    step();
    out_ready = 1'b1;
    flush = 1'b1;
    drive_req(9, 32'd0, 32'd0, 32'h420, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: valid=%b required 0", out_valid);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || resolved_count !== 16'(sat16(exp_res)) ||
        taken_count !== 16'(sat16(exp_tkn))) begin
      n_fail++;
      $display("FAIL flush_counters: valid=%b res=%0d tkn=%0d required 0 %0d %0d",
               out_valid, resolved_count, taken_count, exp_res, exp_tkn);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    drive_req(12, 32'd3, 32'd3, 32'h500, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_taken !== 1'b0 || illegal_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_held: valid=%b taken=%b ill=%b required 1 0 0",
               out_valid, out_taken, illegal_seen);
    end
    out_ready = 1'b1;
    step();
    note_delivery(12, 1'b0);
    n_cmp++;
    if (illegal_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_set: ill=%b required 1", illegal_seen);
    end
    drive_req(1, 32'd2, 32'd2, 32'h504, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    note_delivery(1, 1'b1);
    n_cmp++;
    if (illegal_seen !== 1'b1 || resolved_count !== 16'(sat16(exp_res))) begin
      n_fail++;
      $display("FAIL illegal_sticky: ill=%b res=%0d required 1 %0d",
               illegal_seen, resolved_count, exp_res);
    end
  endtask

  task automatic test_back_to_back();
    int prev_c = 0;
    bit prev_tk = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int          c = $urandom_range(0, 9);
      logic [31:0] a = rand_op();
      logic [31:0] b = rand_op();
      logic [31:0] t = 32'h700 + 32'(i * 4);
      bit          tk = ref_taken(c, a, b);
      drive_req(c, a, b, t, 1'b0, 1'b0);
      step();
      if (i > 0) note_delivery(prev_c, prev_tk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_taken !== tk || out_target !== t) begin
        n_fail++;
        $display("FAIL b2b_%0d: valid=%b taken=%b target=%h required 1 %b %h",
                 i, out_valid, out_taken, out_target, tk, t);
      end
      prev_c = c;
      prev_tk = tk;
    end
    in_valid = 1'b0;
    step();
    note_delivery(prev_c, prev_tk);
    n_cmp++;
    if (resolved_count !== 16'(sat16(exp_res)) || taken_count !== 16'(sat16(exp_tkn))) begin
      n_fail++;
      $display("FAIL b2b_counters: res=%0d tkn=%0d required %0d %0d",
               resolved_count, taken_count, exp_res, exp_tkn);
    end
    n_cmp++;
    if (resolved_count2 !== 2'(sat2(exp_res)) || taken_count2 !== 2'(sat2(exp_tkn))) begin
      n_fail++;
      $display("FAIL sat_counters: res=%0d tkn=%0d required %0d %0d",
               resolved_count2, taken_count2, sat2(exp_res), sat2(exp_tkn));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      int          c = $urandom_range(0, 15);
      int          w = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      logic [31:0] t = 32'($urandom());
      logic [31:0] a, b;
      bit          tk;
      out_ready = 1'b0;
      a = rand_op();
      b = ($urandom_range(0, 3) == 0) ? a : rand_op();
      drive_req(c, a, b, t, (w > 0), (w > 0) && ($urandom_range(0, 1) == 1));
      step();
      in_valid = 1'b0;
      for (int k = 0; k < w; k++) begin
        in_a = 32'($urandom());
        in_b = 32'($urandom());
        step();
      end
      if (w > 0) begin
        a = rand_op();
        b = ($urandom_range(0, 3) == 0) ? a : rand_op();
        in_a = a;
        in_b = b;
        in_a_pending = 1'b0;
        in_b_pending = 1'b0;
        step();
      end
      tk = ref_taken(c, a, b);
      n_cmp++;
      if (out_valid !== 1'b1 || out_taken !== tk || out_target !== t) begin
        n_fail++;
        $display("FAIL rand_%0d code%0d: valid=%b taken=%b target=%h required 1 %b %h",
                 n, c, out_valid, out_taken, out_target, tk, t);
      end
      repeat ($urandom_range(0, 2)) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      note_delivery(c, tk);
      n_cmp++;
      if (out_valid !== 1'b0 || resolved_count !== 16'(sat16(exp_res)) ||
          taken_count !== 16'(sat16(exp_tkn)) || illegal_seen !== exp_ill) begin
        n_fail++;
        $display("FAIL rand_stats_%0d: valid=%b res=%0d tkn=%0d ill=%b required 0 %0d %0d %b",
                 n, out_valid, resolved_count, taken_count, illegal_seen, exp_res, exp_tkn,
                 exp_ill);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_req(1, 32'd1, 32'd1, 32'h600, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_wait: in_ready=%b valid=%b required 0 0", in_ready, out_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_taken !== 1'b0 ||
        out_target !== 32'h0 || illegal_seen !== 1'b0 || resolved_count !== 16'h0 ||
        taken_count !== 16'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: rdy=%b vld=%b tk=%b tgt=%h ill=%b res=%0d tkn=%0d required 1 0 0 0 0 0 0",
               in_ready, out_valid, out_taken, out_target, illegal_seen, resolved_count,
               taken_count);
    end
    n_cmp++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || out_taken2 !== 1'b0 ||
        out_target2 !== 32'h0 || illegal_seen2 !== 1'b0 || resolved_count2 !== 2'h0 ||
        taken_count2 !== 2'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs2: rdy=%b vld=%b tk=%b tgt=%h ill=%b res=%0d tkn=%0d required 1 0 0 0 0 0 0",
               in_ready2, out_valid2, out_taken2, out_target2, illegal_seen2, resolved_count2,
               taken_count2);
    end
    in_a_pending = 1'b0;
    in_b_pending = 1'b0;
    step();
    reset_n = 1'b1;
    exp_res = 0;
    exp_tkn = 0;
    exp_ill = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_after: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_eq();
    test_compares();
    test_pending();
    test_stall();
    test_flush();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
